mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
Sequencer for the MEM stage's data-memory access.
- Takes the load/store request in MEM, drives a req/gnt/rvalid data-memory port and holds the pipeline with a stall.
- Formats load data: lane select and sign/zero extension.
- Presents the finished load result to the MEM/WB pipeline register on its completion cycle.
- Flags misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT, 15: max cycles spent in REQ+WAIT_R before abort.
- TO_W, 4: timeout counter width; must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- mem_valid  in  1  valid instruction in MEM stage
- mem_read  in  1  load
- mem_write  in  1  store
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- mem_unsigned  in  1  zero-extend load (LBU/LHU)
- mem_addr  in  32  byte address (ALU result)
- mem_wdata  in  32  store data (rs2)
- dmem_req  out  1  request valid
- dmem_we  out  1  write enable
- dmem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data
- pipe_stall  out  1  hold PC/IF-ID/ID-EX/EX-MEM, bubble MEM/WB
- load_valid  out  1  load result valid this cycle
- load_data  out  32  formatted load result
- misaligned  out  1  combinational: access misaligned, not issued
- access_fault  out  1  one-cycle pulse: timeout abort

Behaviour:
- Reset: state IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0, load_valid=0, load_data=0, access_fault=0, timeout counter=0. pipe_stall=0 and misaligned=0 while reset is high.
- acc = mem_valid & (mem_read | mem_write).
- If mem_read and mem_write are both set, it is a read; the write is ignored.
- Misaligned when half with addr[0]=1, or word with addr[1:0]!=0.
- IDLE:
  - If acc & !misaligned: latch we, addr, be, wdata, size and unsigned, then go to REQ. pipe_stall=1 in this cycle.
  - If acc & misaligned: misaligned=1, no request, no stall, stay in IDLE.
  - A dmem_rvalid arriving in IDLE is ignored.
- REQ:
  - dmem_req=1, pipe_stall=1, and all dmem_* outputs are held stable until gnt.
  - gnt with write: go to DONE.
  - gnt with read: if rvalid is also high in the same cycle, capture the data and go to DONE; otherwise go to WAIT_R.
- WAIT_R: dmem_req=0, pipe_stall=1. On rvalid, capture the formatted data and go to DONE.
- DONE:
  - pipe_stall=0.
  - load_valid=1 for a read.
  - Go to IDLE.
  - The pipeline advances at the end of this cycle; MEM/WB captures load_data at that edge.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ or WAIT_R.
  - When it reaches TIMEOUT, go to DONE with load_data=0, access_fault=1 and load_valid=1 for a read.
  - A later stray rvalid is ignored.
- Minimum latency:
  - Store with immediate gnt: 3 cycles (IDLE, REQ, DONE), 2 of them stalled.
  - Load with gnt and rvalid in the same cycle: 3 cycles.
- dmem_be:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- dmem_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load format:
  - Select byte rdata[8*a+7:8*a] or half rdata[16*a[1]+15:16*a[1]], where a=addr[1:0].
  - Sign-extend unless unsigned; word passes through.
- load_valid and access_fault are deasserted in every state other than DONE.
- Reset in any state forces IDLE in the next cycle and drops dmem_req immediately after the edge. A grant in flight is abandoned.

Decomposition:
- Package riscv_mem_pkg: state encoding (IDLE, REQ, WAIT_R, DONE); size codes SZ_B, SZ_H, SZ_W; TIMEOUT default.
- Sub-module load_formatter: combinational lane extract and sign/zero extension from rdata, addr[1:0], size and unsigned. Reused by any later cache path.

Test Plan:
- Store word: addr 0x100, wdata 0xDEADBEEF, gnt in the first REQ cycle -> dmem_be=1111, dmem_addr=0x100, we=1; stall for 2 cycles; DONE with load_valid=0.
- Load byte signed: addr 0x203, rdata 0x80FF_0000, gnt then rvalid 2 cycles later -> load_data=0xFFFFFF80; stall for 4 cycles; load_valid for 1 cycle.
- Load half unsigned: addr 0x202, rdata 0x8001_1234, gnt and rvalid in the same cycle -> load_data=0x00008001; 3-cycle latency.
- Misaligned word load at 0x101 -> misaligned=1, dmem_req never asserted, pipe_stall=0.
- gnt withheld for 15 cycles on a load -> access_fault pulse, load_data=0; a later rvalid is ignored and state returns to IDLE.
- Reset asserted in WAIT_R -> dmem_req=0, state IDLE; a subsequent rvalid produces no load_valid.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access sequencer.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int TIMEOUT_DEF = 15;

  // Reserved size 2'b11 falls into the word arm of every helper.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_B:    return {4{wdata[7:0]}};
      SZ_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_formatter.sv
// Lane extract and sign/zero extension of a 32-bit read word.
module load_formatter
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [15:0] half;

  assign shifted = rdata >> {off, 3'b000};
  assign half    = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (size)
      SZ_B:    data = zext ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    data = zext ? {16'b0, half} : {{16{half[15]}}, half};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/gnt/rvalid port, pipeline stall,
// load formatting, misalignment detection and timeout abort.
module mem_access_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        pipe_stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        access_fault
);

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            rd_q;
  logic            zext_q;
  logic [1:0]      off_q;
  logic [1:0]      size_q;

  logic            acc;
  logic            mis;
  logic            start;
  logic            timeout_hit;
  logic [31:0]     fmt_data;

  assign acc         = mem_valid & (mem_read | mem_write);
  assign mis         = is_misaligned(mem_size, mem_addr[1:0]);
  assign start       = (state == IDLE) & acc & ~mis;
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));

  // Stall is raised in the accepting IDLE cycle so MEM inputs stay put.
  assign misaligned = ~reset & (state == IDLE) & acc & mis;
  assign pipe_stall = ~reset & (start | (state == REQ) | (state == WAIT_R));

  load_formatter u_fmt (
    .rdata (dmem_rdata),
    .off   (off_q),
    .size  (size_q),
    .zext  (zext_q),
    .data  (fmt_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      to_cnt       <= '0;
      rd_q         <= 1'b0;
      zext_q       <= 1'b0;
      off_q        <= 2'b00;
      size_q       <= SZ_B;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= '0;
      load_valid   <= 1'b0;
      load_data    <= '0;
      access_fault <= 1'b0;
    end else begin
      load_valid   <= 1'b0;
      access_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= REQ;
            to_cnt     <= '0;
            rd_q       <= mem_read;
            zext_q     <= mem_unsigned;
            off_q      <= mem_addr[1:0];
            size_q     <= mem_size;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write & ~mem_read;
            dmem_addr  <= {mem_addr[31:2], 2'b00};
            dmem_wdata <= lane_wdata(mem_size, mem_wdata);
            dmem_be    <= byte_en(mem_size, mem_addr[1:0]);
          end
        end
        REQ: begin
          to_cnt <= to_cnt + 1'b1;
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (!rd_q) begin
              state <= DONE;
            end else if (dmem_rvalid) begin
              state      <= DONE;
              load_valid <= 1'b1;
              load_data  <= fmt_data;
            end else begin
              state <= WAIT_R;
            end
          end else if (timeout_hit) begin
            state        <= DONE;
            dmem_req     <= 1'b0;
            load_valid   <= rd_q;
            load_data    <= '0;
            access_fault <= 1'b1;
          end
        end
        WAIT_R: begin
          to_cnt <= to_cnt + 1'b1;
          if (dmem_rvalid) begin
            state      <= DONE;
            load_valid <= 1'b1;
            load_data  <= fmt_data;
          end else if (timeout_hit) begin
            state        <= DONE;
            load_valid   <= 1'b1;
            load_data    <= '0;
            access_fault <= 1'b1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule
